// File: rtl/div_pkg.sv
// Shared types and defaults for the pipelined M-extension divider.
package div_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_TAG_W = 4;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  // Contents of one stage register in the default configuration.
  typedef struct packed {
    logic [DIV_XLEN:0]    rem;
    logic [DIV_XLEN-1:0]  quo;
    logic [DIV_XLEN-1:0]  dvd;
    logic [DIV_XLEN-1:0]  dvs;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div0;
    div_op_e              op;
    logic [DIV_TAG_W-1:0] tag;
    logic                 valid;
  } div_stage_t;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_pipe_stage.sv
// One registered divider stage: BITS_PER_STAGE restoring shift/compare/subtract steps.
module div_pipe_stage
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = DIV_XLEN,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_W          = DIV_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [XLEN:0]    rem_i,
  input  logic [XLEN-1:0]  quo_i,
  input  logic [XLEN-1:0]  dvd_i,
  input  logic [XLEN-1:0]  dvs_i,
  input  logic             qneg_i,
  input  logic             rneg_i,
  input  logic             div0_i,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [XLEN:0]    rem_o,
  output logic [XLEN-1:0]  quo_o,
  output logic [XLEN-1:0]  dvd_o,
  output logic [XLEN-1:0]  dvs_o,
  output logic             qneg_o,
  output logic             rneg_o,
  output logic             div0_o,
  output logic [1:0]       op_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [XLEN:0]    rem_d;
  logic [XLEN-1:0]  quo_d;
  logic [XLEN-1:0]  dvd_d;

  logic             valid_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             div0_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;

  // Bring the next dividend bit into the remainder, subtract the divisor when it fits.
  always_comb begin
    rem_d = rem_i;
    quo_d = quo_i;
    dvd_d = dvd_i;
    for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
      rem_d = (XLEN+1)'({rem_d, dvd_d[XLEN-1]});
      dvd_d = dvd_d << 1;
      if (rem_d >= {1'b0, dvs_i}) begin
        rem_d = rem_d - {1'b0, dvs_i};
        quo_d = {quo_d[XLEN-2:0], 1'b1};
      end else begin
        quo_d = {quo_d[XLEN-2:0], 1'b0};
      end
    end
  end

  // Only the valid bit is cleared; data is meaningless while valid is low.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
    end
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_i;
    qneg_q <= qneg_i;
    rneg_q <= rneg_i;
    div0_q <= div0_i;
    op_q   <= op_i;
    tag_q  <= tag_i;
  end

  assign valid_o = valid_q;
  assign rem_o   = rem_q;
  assign quo_o   = quo_q;
  assign dvd_o   = dvd_q;
  assign dvs_o   = dvs_q;
  assign qneg_o  = qneg_q;
  assign rneg_o  = rneg_q;
  assign div0_o  = div0_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/div_pipe.sv
// Fully pipelined signed/unsigned divider: entry sign conversion, NSTAGE restoring
// stages, and a registered fix-up stage for negation and divide-by-zero.
module div_pipe
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = DIV_XLEN,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_W          = DIV_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic [XLEN-1:0]  quotient,
  output logic [XLEN-1:0]  remainder,
  output logic [1:0]       op_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             done
);

  localparam int unsigned NSTAGE = XLEN / BITS_PER_STAGE;

  logic             sgn_d;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [XLEN-1:0]  mag_a_d;
  logic [XLEN-1:0]  mag_b_d;

  logic             in_valid_q;
  logic [XLEN-1:0]  in_dvd_q;
  logic [XLEN-1:0]  in_dvs_q;
  logic             in_qneg_q;
  logic             in_rneg_q;
  logic             in_div0_q;
  logic [1:0]       in_op_q;
  logic [TAG_W-1:0] in_tag_q;

  logic [NSTAGE:0]              st_valid;
  logic [NSTAGE:0][XLEN:0]      st_rem;
  logic [NSTAGE:0][XLEN-1:0]    st_quo;
  logic [NSTAGE:0][XLEN-1:0]    st_dvd;
  logic [NSTAGE:0][XLEN-1:0]    st_dvs;
  logic [NSTAGE:0]              st_qneg;
  logic [NSTAGE:0]              st_rneg;
  logic [NSTAGE:0]              st_div0;
  logic [NSTAGE:0][1:0]         st_op;
  logic [NSTAGE:0][TAG_W-1:0]   st_tag;

  logic [XLEN-1:0]  q_mag_d;
  logic [XLEN-1:0]  r_mag_d;
  logic [XLEN-1:0]  quotient_d;
  logic [XLEN-1:0]  remainder_d;

  logic             done_q;
  logic [XLEN-1:0]  quotient_q;
  logic [XLEN-1:0]  remainder_q;
  logic [1:0]       op_out_q;
  logic [TAG_W-1:0] tag_out_q;

  logic             unused_tail;

  // Signed ops divide magnitudes; the result signs travel as flags.
  always_comb begin
    sgn_d   = is_signed_op(div_op_e'(op));
    a_neg_d = sgn_d & dividend[XLEN-1];
    b_neg_d = sgn_d & divisor[XLEN-1];
    mag_a_d = a_neg_d ? (~dividend + XLEN'(1)) : dividend;
    mag_b_d = b_neg_d ? (~divisor + XLEN'(1)) : divisor;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= start;
    end
    in_dvd_q  <= mag_a_d;
    in_dvs_q  <= mag_b_d;
    in_qneg_q <= a_neg_d ^ b_neg_d;
    in_rneg_q <= a_neg_d;
    in_div0_q <= (divisor == '0);
    in_op_q   <= op;
    in_tag_q  <= tag_in;
  end

  assign st_valid[0] = in_valid_q;
  assign st_rem[0]   = '0;
  assign st_quo[0]   = '0;
  assign st_dvd[0]   = in_dvd_q;
  assign st_dvs[0]   = in_dvs_q;
  assign st_qneg[0]  = in_qneg_q;
  assign st_rneg[0]  = in_rneg_q;
  assign st_div0[0]  = in_div0_q;
  assign st_op[0]    = in_op_q;
  assign st_tag[0]   = in_tag_q;

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    div_pipe_stage #(
      .XLEN           (XLEN),
      .BITS_PER_STAGE (BITS_PER_STAGE),
      .TAG_W          (TAG_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .flush_i (flush),
      .valid_i (st_valid[g]),
      .rem_i   (st_rem[g]),
      .quo_i   (st_quo[g]),
      .dvd_i   (st_dvd[g]),
      .dvs_i   (st_dvs[g]),
      .qneg_i  (st_qneg[g]),
      .rneg_i  (st_rneg[g]),
      .div0_i  (st_div0[g]),
      .op_i    (st_op[g]),
      .tag_i   (st_tag[g]),
      .valid_o (st_valid[g+1]),
      .rem_o   (st_rem[g+1]),
      .quo_o   (st_quo[g+1]),
      .dvd_o   (st_dvd[g+1]),
      .dvs_o   (st_dvs[g+1]),
      .qneg_o  (st_qneg[g+1]),
      .rneg_o  (st_rneg[g+1]),
      .div0_o  (st_div0[g+1]),
      .op_o    (st_op[g+1]),
      .tag_o   (st_tag[g+1])
    );
  end

  // Dividend bits are fully consumed and the divisor is no longer needed after the last stage.
  assign unused_tail = ^{st_dvd[NSTAGE], st_dvs[NSTAGE]};

  // Divide by zero: the remainder magnitude is |dividend|, so re-applying its sign restores it.
  always_comb begin
    q_mag_d     = st_quo[NSTAGE];
    r_mag_d     = XLEN'(st_rem[NSTAGE]);
    quotient_d  = st_qneg[NSTAGE] ? (~q_mag_d + XLEN'(1)) : q_mag_d;
    remainder_d = st_rneg[NSTAGE] ? (~r_mag_d + XLEN'(1)) : r_mag_d;
    if (st_div0[NSTAGE]) begin
      quotient_d = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      op_out_q    <= '0;
      tag_out_q   <= '0;
    end else begin
      done_q <= st_valid[NSTAGE] & ~flush;
      if (st_valid[NSTAGE] && !flush) begin
        quotient_q  <= quotient_d;
        remainder_q <= remainder_d;
        op_out_q    <= st_op[NSTAGE];
        tag_out_q   <= st_tag[NSTAGE];
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign op_out    = op_out_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_div_pipe.sv
// Bench for div_pipe: one-stage-per-bit and four-bits-per-stage builds side by side.
module tb_div_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int          NVEC  = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             rst_s   [2];
  logic             start_s [2];
  logic [1:0]       op_s    [2];
  logic [XLEN-1:0]  a_s     [2];
  logic [XLEN-1:0]  b_s     [2];
  logic [TAG_W-1:0] tag_s   [2];
  logic             flush_s [2];
  logic [XLEN-1:0]  q_s     [2];
  logic [XLEN-1:0]  r_s     [2];
  logic [1:0]       opo_s   [2];
  logic [TAG_W-1:0] tago_s  [2];
  logic             done_s  [2];

  div_pipe #(.XLEN(XLEN), .BITS_PER_STAGE(1), .TAG_W(TAG_W)) u_dut1 (
    .clock(clock), .reset(rst_s[0]), .start(start_s[0]), .op(op_s[0]),
    .dividend(a_s[0]), .divisor(b_s[0]), .tag_in(tag_s[0]), .flush(flush_s[0]),
    .quotient(q_s[0]), .remainder(r_s[0]), .op_out(opo_s[0]), .tag_out(tago_s[0]),
    .done(done_s[0])
  );

  div_pipe #(.XLEN(XLEN), .BITS_PER_STAGE(4), .TAG_W(TAG_W)) u_dut4 (
    .clock(clock), .reset(rst_s[1]), .start(start_s[1]), .op(op_s[1]),
    .dividend(a_s[1]), .divisor(b_s[1]), .tag_in(tag_s[1]), .flush(flush_s[1]),
    .quotient(q_s[1]), .remainder(r_s[1]), .op_out(opo_s[1]), .tag_out(tago_s[1]),
    .done(done_s[1])
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == 2'd0 || op == 2'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // One isolated operation: checks latency, results, metadata and a one-cycle done pulse.
  task automatic run_vec(input int sel, input int idx, input int lat_exp);
    int lat;
    string nm;
    nm = $sformatf("dut%0d vec%0d", (sel == 0) ? 1 : 4, idx);
    op_s[sel]    = vecs[idx].op;
    a_s[sel]     = vecs[idx].a;
    b_s[sel]     = vecs[idx].b;
    tag_s[sel]   = 4'(idx);
    start_s[sel] = 1'b1;
    tick();
    start_s[sel] = 1'b0;
    lat = 0;
    while (!done_s[sel] && lat < 60) begin
      tick();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(lat_exp));
    check({nm, " quotient"}, q_s[sel], vecs[idx].q);
    check({nm, " remainder"}, r_s[sel], vecs[idx].r);
    check({nm, " op/tag"}, {26'd0, opo_s[sel], tago_s[sel]}, {26'd0, vecs[idx].op, 4'(idx)});
    tick();
    check({nm, " done pulse width"}, 32'(done_s[sel]), 32'd0);
  endtask

  initial begin
    int ndone;
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b1; start_s[s] = 1'b0; op_s[s] = 2'd0; a_s[s] = '0;
      b_s[s] = '0; tag_s[s] = '0; flush_s[s] = 1'b0;
    end

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[4]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{2'd1, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
    vecs[8]  = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[9]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[10] = '{2'd3, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[11] = '{2'd1, 32'd3,          32'hFFFF_FFFF,  32'd0,          32'd3};

    tick(); tick(); tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset outputs dut%0d", s), {done_s[s], 1'b0, opo_s[s], tago_s[s]}, 32'd0);
      check($sformatf("reset q/r dut%0d", s), q_s[s] | r_s[s], 32'd0);
      rst_s[s] = 1'b0;
    end
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(0, i, 33);
    for (int i = 0; i < NVEC; i++) run_vec(1, i, 9);

    // Back-to-back stream on the single-bit build, compared in order against the model.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [1:0]  op;
          logic [31:0] a, b;
          logic [63:0] res;
          op = 2'($urandom_range(0, 3));
          a  = $urandom;
          b  = $urandom;
          if (i % 8 == 2) b = 32'd0;
          if (i % 8 == 5) b = 32'($urandom_range(1, 15));
          if (i % 8 == 6) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
          if (i % 8 == 7) a = 32'($urandom_range(0, 200));
          if (i == 17) begin op = 2'd0; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          res = ref_div(op, a, b);
          exp_q.push_back('{op, 4'(i % 16), res[63:32], res[31:0]});
          op_s[0] = op; a_s[0] = a; b_s[0] = b; tag_s[0] = 4'(i % 16); start_s[0] = 1'b1;
          tick();
        end
        start_s[0] = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (!done_s[0] && w < 80) begin
          tick();
          w++;
        end
        for (int i = 0; i < 40; i++) begin
          exp_t e;
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL stream[%0d]: no expected entry queued", i);
          end else begin
            e = exp_q.pop_front();
            if (done_s[0] === 1'b1 && q_s[0] === e.q && r_s[0] === e.r &&
                opo_s[0] === e.op && tago_s[0] === e.tag) begin
              n_pass++;
            end else begin
              $display("FAIL stream[%0d]: got done=%0b q=0x%0h r=0x%0h op=%0d tag=%0d, expected done=1 q=0x%0h r=0x%0h op=%0d tag=%0d",
                       i, done_s[0], q_s[0], r_s[0], opo_s[0], tago_s[0], e.q, e.r, e.op, e.tag);
            end
          end
          tick();
        end
        check("stream done after last", 32'(done_s[0]), 32'd0);
      end
    join

    // Ten in flight, then flush together with a new start: nothing may complete.
    for (int i = 0; i < 10; i++) begin
      op_s[0] = 2'd1; a_s[0] = 32'(50 + i); b_s[0] = 32'd3; tag_s[0] = 4'(i); start_s[0] = 1'b1;
      tick();
    end
    flush_s[0] = 1'b1;
    a_s[0] = 32'd99;
    tick();
    flush_s[0] = 1'b0;
    start_s[0] = 1'b0;
    ndone = 0;
    for (int c = 0; c < 45; c++) begin
      if (done_s[0]) ndone++;
      tick();
    end
    check("dut1 done after flush", 32'(ndone), 32'd0);
    run_vec(0, 0, 33);

    // Reset in the middle of a stream on the four-bit build.
    for (int i = 0; i < 14; i++) begin
      op_s[1] = 2'd3; a_s[1] = 32'(1000 + i * 37); b_s[1] = 32'd7; tag_s[1] = 4'(i + 1);
      start_s[1] = 1'b1;
      tick();
    end
    check("dut4 done before reset", 32'(done_s[1]), 32'd1);
    check("dut4 tag before reset", 32'(tago_s[1]), 32'd5);
    rst_s[1] = 1'b1;
    tick();
    rst_s[1] = 1'b0;
    start_s[1] = 1'b0;
    check("dut4 done after reset", 32'(done_s[1]), 32'd0);
    check("dut4 quotient after reset", q_s[1], 32'd0);
    check("dut4 remainder after reset", r_s[1], 32'd0);
    check("dut4 op/tag after reset", {26'd0, opo_s[1], tago_s[1]}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_s[1]) ndone++;
      tick();
    end
    check("dut4 done after mid-stream reset", 32'(ndone), 32'd0);
    run_vec(1, 6, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_pipe.md
# div_pipe

Parametrised, fully pipelined integer divider for the RISC-V M-extension datapath. It succeeds the fixed 32-stage unsigned divider and adds configurable width, configurable bits retired per pipeline stage, signed and unsigned DIV/DIVU/REM/REMU semantics, divide-by-zero and overflow results, a tag field carried alongside each operation, and a synchronous flush. It accepts one operation per cycle with no backpressure and sits beside the ALU in the execute stage.

## Interface
- `XLEN`, 32: operand and result width.
- `BITS_PER_STAGE`, 1: quotient bits resolved per registered stage. Must divide `XLEN`. `NSTAGE = XLEN/BITS_PER_STAGE`.
- `TAG_W`, 4: width of the opaque tag carried with each operation.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: operation valid this cycle.
- `op` input 2: `DIV`=0, `DIVU`=1, `REM`=2, `REMU`=3.
- `dividend` input XLEN: dividend operand.
- `divisor` input XLEN: divisor operand.
- `tag_in` input TAG_W: tag echoed back with the result.
- `flush` input 1: discard all in-flight operations.
- `quotient` output XLEN: final quotient.
- `remainder` output XLEN: final remainder.
- `op_out` output 2: `op` of the completing operation.
- `tag_out` output TAG_W: tag of the completing operation.
- `done` output 1: outputs are valid this cycle (single-cycle pulse per operation).

## Operation
- Signed ops (`DIV`, `REM`):
  - Operands are converted to magnitudes at entry.
  - `neg_q = sign(dividend) ^ sign(divisor)`.
  - `neg_r = sign(dividend)`.
  - Both flags travel with the operation through the pipe.
- Unsigned ops: magnitudes are the raw operands, and both flags are 0.
- Core algorithm: restoring division, MSB first. Each stage performs `BITS_PER_STAGE` shift/compare/subtract iterations combinationally, then registers the partial remainder, partial quotient, remaining dividend bits, divisor, flags, op and tag.
- The partial remainder is `XLEN+1` bits wide internally, so no compare overflows.
- The output stage applies the fix-up: conditional two's-complement negation of the quotient and remainder, then the special cases below.
- Divide by zero (`divisor==0`): the `div0` flag is captured at entry and carried through the pipe.
  - `quotient` = all ones.
  - `remainder` = original `dividend`.
  - This holds for all four ops.
- Signed overflow (`DIV`/`REM`, dividend = -2^(XLEN-1), divisor = -1):
  - `quotient` = dividend.
  - `remainder` = 0.
  - This falls out of the magnitude arithmetic with no special case. The bench must confirm it.
- Both `quotient` and `remainder` are always driven. `op_out` tells the consumer which one it needs.
- `done` and `tag_out` follow their operation exactly. Ordering is strictly FIFO.

## Timing
- Latency is `NSTAGE+1` cycles: `start` sampled at edge k gives `done` high after edge k+`NSTAGE`+1. For the default configuration this is 33.
- Throughput is one operation per cycle. `start` may be high every cycle.
- Per-stage valid bits form a shift register. Data registers are clocked every cycle, and their contents matter only when the matching valid bit is set.
- Reset values:
  - `done`, `quotient`, `remainder`, `op_out` and `tag_out` are 0.
  - All stage valid bits are 0.
- `reset` or `flush` mid-operation:
  - Every stage valid bit clears at that edge.
  - `done` stays low until an operation accepted after the flush completes.
- `start` coincident with `flush` or `reset`: the new operation is dropped.
- `start` low: nothing enters the pipe, and no `done` is produced `NSTAGE+1` cycles later.

## Structure
- Package `div_pkg` holds:
  - the `div_op_e` enum;
  - the `div_stage_t` struct: partial remainder, partial quotient, dividend shift, divisor, `neg_q`, `neg_r`, `div0`, op, tag, valid;
  - the default `XLEN` localparam.
- Sub-module `div_pipe_stage`, parametrised by `XLEN`, `BITS_PER_STAGE` and `TAG_W`, performs one stage's iterations and owns that stage's register. It is instantiated `NSTAGE` times in a generate loop.
- The entry sign-conversion logic and the output fix-up register live in `div_pipe`.

## Test plan
- `DIVU` 100/7 -> after 33 cycles `done`=1, `quotient`=14, `remainder`=2. `done` is high for exactly one cycle.
- Signed cases:
  - `DIV` -7/2 -> `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - `REM` 7/-2 -> `quotient`=0xFFFFFFFD, `remainder`=1.
- Divide by zero:
  - `DIV` -5/0 -> `quotient`=0xFFFFFFFF, `remainder`=0xFFFFFFFB.
  - `DIVU` 5/0 -> `quotient`=0xFFFFFFFF, `remainder`=5.
- Overflow: `DIV` 0x80000000/0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0.
- Streaming:
  - 40 back-to-back random operations with tags 0..15 repeating -> results match the reference model in order, with `done` contiguous.
  - Then assert `flush` with 10 operations in flight -> no `done` for those 10.
- `BITS_PER_STAGE`=4 build -> latency is 9 cycles. `DIVU` 0xFFFFFFFF/3 gives `quotient`=0x55555555, `remainder`=0.
- Same `BITS_PER_STAGE`=4 build, `reset` mid-stream -> all outputs 0 the next cycle.
